// File: rtl/frame_rd_pkg.sv
// Shared types and constants for the frame read controller: SRAM region map,
// descriptor layout, FSM states and read-tag layout.
package frame_rd_pkg;

  localparam int unsigned pDEPTH_RAM = 4606;
  localparam int unsigned pREG0_HI   = 1534;
  localparam int unsigned pREG1_HI   = 3070;
  localparam int unsigned AW         = $clog2(pDEPTH_RAM);

  typedef logic [AW-1:0] addr_t;

  localparam addr_t DepthRam = AW'(pDEPTH_RAM);
  localparam addr_t Reg0Lo   = '0;
  localparam addr_t Reg0Hi   = AW'(pREG0_HI);
  localparam addr_t Reg1Lo   = AW'(pREG0_HI + 1);
  localparam addr_t Reg1Hi   = AW'(pREG1_HI);
  localparam addr_t Reg2Lo   = AW'(pREG1_HI + 1);
  localparam addr_t Reg2Hi   = AW'(pDEPTH_RAM - 1);

  typedef struct packed {
    logic [1:0] extra;
    addr_t      end_addr;
    addr_t      start_addr;
  } desc_t;

  typedef enum logic [0:0] {
    StIdle,
    StRead
  } rd_state_e;

  // Per-word attributes that travel alongside the SRAM read.
  typedef struct packed {
    logic       sof;
    logic       eof;
    logic [3:0] be;
    logic [1:0] region;
  } meta_t;

  typedef struct packed {
    logic  v;
    meta_t meta;
  } tag_t;

  typedef struct packed {
    meta_t       meta;
    logic [31:0] data;
  } skid_t;

  function automatic logic [3:0] be_from_extra(input logic [1:0] extra);
    logic [3:0] be;
    unique case (extra)
      2'd0:    be = 4'hF;
      2'd1:    be = 4'h1;
      2'd2:    be = 4'h3;
      default: be = 4'h7;
    endcase
    return be;
  endfunction

  function automatic logic [1:0] region_of(input addr_t a);
    logic [1:0] r;
    if (a <= Reg0Hi) begin
      r = 2'd0;
    end else if (a <= Reg1Hi) begin
      r = 2'd1;
    end else begin
      r = 2'd2;
    end
    return r;
  endfunction

  function automatic addr_t region_lo(input logic [1:0] r);
    addr_t lo;
    case (r)
      2'd0:    lo = Reg0Lo;
      2'd1:    lo = Reg1Lo;
      default: lo = Reg2Lo;
    endcase
    return lo;
  endfunction

  function automatic addr_t region_hi(input logic [1:0] r);
    addr_t hi;
    case (r)
      2'd0:    hi = Reg0Hi;
      2'd1:    hi = Reg1Hi;
      default: hi = Reg2Hi;
    endcase
    return hi;
  endfunction

  // A frame must start inside the SRAM and end in the region it starts in.
  function automatic logic desc_bad(input desc_t d);
    return (d.start_addr >= DepthRam) || (d.end_addr >= DepthRam) ||
           (region_of(d.end_addr) != region_of(d.start_addr));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head read; a write is accepted when full
// only if a read retires an entry in the same cycle.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_wr,
  input  logic [Width-1:0]       i_wdata,
  input  logic                   i_rd,
  output logic [Width-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(Depth):0] o_count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  typedef logic [PtrW-1:0] ptr_t;

  logic [Width-1:0] mem_q [Depth];
  ptr_t             wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             wr_en, rd_en;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CntW'(Depth));
  assign rd_en   = i_rd & ~o_empty;
  assign wr_en   = i_wr & (~o_full | rd_en);
  assign o_rdata = mem_q[rd_ptr_q];
  assign o_count = count_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (rd_en) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= i_wdata;
  end

endmodule

// File: rtl/frame_read_ctrl.sv
// Frame read controller: queues frame descriptors, reads each frame from its
// SRAM region with wrap-around, and streams words out through a skid buffer.
module frame_read_ctrl
  import frame_rd_pkg::*;
#(
  parameter int unsigned pDESC_DEPTH = 8,
  parameter int unsigned pRD_LAT     = 2
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [2*AW+1:0]              i_desc,
  input  logic                         i_desc_we,
  output logic                         o_desc_full,
  output logic [$clog2(pDESC_DEPTH):0] o_desc_cnt,
  output logic [AW-1:0]                o_adr_out,
  output logic                         o_en_read,
  input  logic [31:0]                  i_mem_data,
  output logic [31:0]                  o_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_sof,
  output logic                         o_eof,
  output logic [3:0]                   o_be,
  output logic                         o_frame_done,
  output logic [1:0]                   o_frame_region,
  output logic                         o_err
);

  localparam int unsigned SkidDepth = pRD_LAT + 2;
  localparam int unsigned DescW     = $bits(desc_t);
  localparam int unsigned SkidW     = $bits(skid_t);

  rd_state_e  state_q, state_d;
  addr_t      cur_q, cur_d;
  addr_t      end_q, end_d;
  logic [1:0] extra_q, extra_d;
  logic [1:0] region_q, region_d;
  logic       first_q, first_d;
  logic       err_q, err_d;

  logic             desc_pop, desc_empty, desc_full, desc_push_err, bad_desc;
  logic [DescW-1:0] desc_rdata;
  desc_t            desc_head;

  logic  issue, credit, last_word;
  tag_t  tag_q [pRD_LAT];
  tag_t  issue_tag;
  logic [31:0] inflight;

  skid_t                       skid_wdata, skid_head;
  logic [SkidW-1:0]            skid_rdata;
  logic                        skid_empty, skid_full, skid_pop;
  logic [$clog2(SkidDepth):0]  skid_cnt;

  sync_fifo #(
    .Width(DescW),
    .Depth(pDESC_DEPTH)
  ) u_desc_fifo (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_wr   (i_desc_we),
    .i_wdata(i_desc),
    .i_rd   (desc_pop),
    .o_rdata(desc_rdata),
    .o_full (desc_full),
    .o_empty(desc_empty),
    .o_count(o_desc_cnt)
  );

  assign desc_head     = desc_t'(desc_rdata);
  assign o_desc_full   = desc_full;
  assign desc_push_err = i_desc_we & desc_full & ~desc_pop;

  // Every issued read owns a skid slot until its word is accepted downstream.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(pRD_LAT); i++) begin
      inflight = inflight + 32'(tag_q[i].v);
    end
  end

  assign credit    = ~skid_full & ((32'(skid_cnt) + inflight) < 32'(SkidDepth));
  assign last_word = (cur_q == end_q);

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    end_d     = end_q;
    extra_d   = extra_q;
    region_d  = region_q;
    first_d   = first_q;
    desc_pop  = 1'b0;
    bad_desc  = 1'b0;
    issue     = 1'b0;
    issue_tag = '0;
    unique case (state_q)
      StIdle: begin
        if (!desc_empty) begin
          desc_pop = 1'b1;
          if (desc_bad(desc_head)) begin
            bad_desc = 1'b1;
          end else begin
            cur_d    = desc_head.start_addr;
            end_d    = desc_head.end_addr;
            extra_d  = desc_head.extra;
            region_d = region_of(desc_head.start_addr);
            first_d  = 1'b1;
            state_d  = StRead;
          end
        end
      end
      StRead: begin
        if (credit) begin
          issue                 = 1'b1;
          issue_tag.v           = 1'b1;
          issue_tag.meta.sof    = first_q;
          issue_tag.meta.eof    = last_word;
          issue_tag.meta.be     = last_word ? be_from_extra(extra_q) : 4'hF;
          issue_tag.meta.region = region_q;
          cur_d   = (cur_q == region_hi(region_q)) ? region_lo(region_q) : cur_q + addr_t'(1);
          first_d = 1'b0;
          if (last_word) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    err_d = desc_push_err | bad_desc;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= StIdle;
      cur_q    <= '0;
      end_q    <= '0;
      extra_q  <= '0;
      region_q <= '0;
      first_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      end_q    <= end_d;
      extra_q  <= extra_d;
      region_q <= region_d;
      first_q  <= first_d;
      err_q    <= err_d;
    end
  end

  // Tag pipe tail lines up with the SRAM word for the same read.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < int'(pRD_LAT); i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= issue_tag;
      for (int i = 1; i < int'(pRD_LAT); i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign o_en_read = issue;
  assign o_adr_out = issue ? cur_q : '0;

  assign skid_wdata = {tag_q[pRD_LAT-1].meta, i_mem_data};

  sync_fifo #(
    .Width(SkidW),
    .Depth(SkidDepth)
  ) u_skid_fifo (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_wr   (tag_q[pRD_LAT-1].v),
    .i_wdata(skid_wdata),
    .i_rd   (skid_pop),
    .o_rdata(skid_rdata),
    .o_full (skid_full),
    .o_empty(skid_empty),
    .o_count(skid_cnt)
  );

  assign skid_head = skid_t'(skid_rdata);
  assign o_valid   = ~skid_empty;
  assign skid_pop  = o_valid & i_ready;

  // Stream fields are forced to zero whenever the head slot is not valid.
  assign o_data         = o_valid ? skid_head.data : '0;
  assign o_sof          = o_valid & skid_head.meta.sof;
  assign o_eof          = o_valid & skid_head.meta.eof;
  assign o_be           = o_valid ? skid_head.meta.be : 4'h0;
  assign o_frame_done   = skid_pop & skid_head.meta.eof;
  assign o_frame_region = o_valid ? skid_head.meta.region : 2'd0;
  assign o_err          = err_q;

endmodule

// File: tb/tb_frame_read_ctrl.sv
// Directed and randomized checks of frame_read_ctrl against a frame-level
// model of address sequences, word attributes and frame completions.
module tb_frame_read_ctrl;
  import frame_rd_pkg::*;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic [2*AW+1:0]   i_desc;
  logic              i_desc_we;
  logic              o_desc_full;
  logic [3:0]        o_desc_cnt;
  logic [AW-1:0]     o_adr_out;
  logic              o_en_read;
  logic [31:0]       i_mem_data;
  logic [31:0]       o_data;
  logic              o_valid;
  logic              i_ready;
  logic              o_sof, o_eof;
  logic [3:0]        o_be;
  logic              o_frame_done;
  logic [1:0]        o_frame_region;
  logic              o_err;

  always #5 i_clk = ~i_clk;

  frame_read_ctrl #(
    .pDESC_DEPTH(8),
    .pRD_LAT    (2)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_desc        (i_desc),
    .i_desc_we     (i_desc_we),
    .o_desc_full   (o_desc_full),
    .o_desc_cnt    (o_desc_cnt),
    .o_adr_out     (o_adr_out),
    .o_en_read     (o_en_read),
    .i_mem_data    (i_mem_data),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_sof         (o_sof),
    .o_eof         (o_eof),
    .o_be          (o_be),
    .o_frame_done  (o_frame_done),
    .o_frame_region(o_frame_region),
    .o_err         (o_err)
  );

  function automatic logic [31:0] mem_f(input logic [AW-1:0] a);
    return 32'hA500_0000 ^ ({19'd0, a} * 32'h0001_0193);
  endfunction

  // SRAM with a two-cycle read latency.
  logic [AW-1:0] a1, a2;
  always @(posedge i_clk) begin
    a1 <= o_adr_out;
    a2 <= a1;
  end
  assign i_mem_data = mem_f(a2);

  typedef struct packed {
    logic [31:0] d;
    logic        sof;
    logic        eof;
    logic [3:0]  be;
  } w_t;

  w_t            got_q[$], exp_q[$];
  logic [AW-1:0] rd_q[$], rde_q[$];
  int            rd_cyc[$];
  logic [1:0]    reg_q[$], rege_q[$];
  int            cyc = 0, err_cnt = 0, outst = 0, max_outst = 0;

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (o_en_read) begin
      rd_q.push_back(o_adr_out);
      rd_cyc.push_back(cyc);
    end
    if (o_valid && i_ready) got_q.push_back({o_data, o_sof, o_eof, o_be});
    if (o_frame_done) reg_q.push_back(o_frame_region);
    if (o_err) err_cnt <= err_cnt + 1;
    if (i_reset) outst <= 0;
    else outst <= outst + int'(o_en_read) - int'(o_valid && i_ready);
    if (outst > max_outst) max_outst <= outst;
  end

  int total = 0, bad = 0;
  int gb, rb, db, eb;
  logic [3:0] be_tab [4] = '{4'hF, 4'h1, 4'h3, 4'h7};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_phase();
    exp_q.delete();
    rde_q.delete();
    rege_q.delete();
    gb = got_q.size();
    rb = rd_q.size();
    db = reg_q.size();
    eb = err_cnt;
  endtask

  task automatic region_bounds(input int s, output int r, output int lo, output int hi);
    if (s <= 1534) begin r = 0; lo = 0; hi = 1534; end
    else if (s <= 3070) begin r = 1; lo = 1535; hi = 3070; end
    else begin r = 2; lo = 3071; hi = 4605; end
  endtask

  // Expected frame: addresses walk from start to end modulo the region size.
  task automatic add_frame(input int s, input int e, input int x);
    int r, lo, hi, size, n, a;
    region_bounds(s, r, lo, hi);
    size = hi - lo + 1;
    n = ((e - s + size) % size) + 1;
    for (int k = 0; k < n; k++) begin
      a = lo + (s - lo + k) % size;
      rde_q.push_back(AW'(a));
      exp_q.push_back({mem_f(AW'(a)), k == 0, k == n - 1, (k == n - 1) ? be_tab[x] : 4'hF});
    end
    rege_q.push_back(2'(r));
  endtask

  task automatic rand_desc(input int maxlen, output int s, output int e, output int x);
    int r, lo, hi, size, len;
    r = $urandom_range(0, 2);
    region_bounds((r == 0) ? 0 : (r == 1) ? 1535 : 3071, r, lo, hi);
    size = hi - lo + 1;
    if ($urandom_range(0, 1) == 1) s = hi - $urandom_range(0, 4);
    else s = lo + $urandom_range(0, size - 1);
    len = $urandom_range(1, maxlen);
    e = lo + (s - lo + len - 1) % size;
    x = $urandom_range(0, 3);
  endtask

  task automatic push_desc(input int s, input int e, input int x);
    @(negedge i_clk);
    i_desc    = {2'(x), AW'(e), AW'(s)};
    i_desc_we = 1'b1;
    @(negedge i_clk);
    i_desc_we = 1'b0;
  endtask

  task automatic wait_frames(input string tag, input int n, input int budget, input bit rnd);
    int c = 0;
    while ((reg_q.size() - db < n) && (c < budget)) begin
      @(negedge i_clk);
      if (rnd) i_ready = ($urandom_range(0, 3) != 0);
      c++;
    end
    i_ready = 1'b1;
    chk({tag, "_frames_done"}, 64'(reg_q.size() - db), 64'(n));
    repeat (4) @(negedge i_clk);
  endtask

  task automatic compare_phase(input string tag);
    chk({tag, "_nwords"}, 64'(got_q.size() - gb), 64'(exp_q.size()));
    chk({tag, "_nreads"}, 64'(rd_q.size() - rb), 64'(rde_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      if (gb + k < got_q.size()) chk($sformatf("%s_word%0d", tag, k), got_q[gb+k], exp_q[k]);
    for (int k = 0; k < rde_q.size(); k++)
      if (rb + k < rd_q.size()) chk($sformatf("%s_addr%0d", tag, k), rd_q[rb+k], rde_q[k]);
    for (int k = 0; k < rege_q.size(); k++)
      if (db + k < reg_q.size()) chk($sformatf("%s_region%0d", tag, k), reg_q[db+k], rege_q[k]);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_en_read"}, o_en_read, 0);
    chk({tag, "_adr"}, o_adr_out, 0);
    chk({tag, "_data"}, o_data, 0);
    chk({tag, "_sof_eof_be"}, {o_sof, o_eof, o_be}, 0);
    chk({tag, "_done_region"}, {o_frame_done, o_frame_region}, 0);
    chk({tag, "_desc_cnt"}, o_desc_cnt, 0);
    chk({tag, "_desc_full"}, o_desc_full, 0);
    chk({tag, "_err"}, o_err, 0);
  endtask

  initial begin
    int s, e, x, vb, c;
    i_reset   = 1'b1;
    i_desc    = '0;
    i_desc_we = 1'b0;
    i_ready   = 1'b1;
    repeat (3) @(negedge i_clk);
    chk_all_zero("reset");
    i_reset = 1'b0;

    // Basic four-word frame in region 0.
    new_phase();
    add_frame(10, 13, 2);
    push_desc(10, 13, 2);
    wait_frames("t1", 1, 200, 1'b0);
    compare_phase("t1");
    if (rd_cyc.size() - rb >= 4) chk("t1_consecutive_reads", 64'(rd_cyc[rb+3] - rd_cyc[rb]), 3);
    if (got_q.size() - gb >= 4) chk("t1_eof_be", got_q[gb+3].be, 4'h3);

    // Region wraps and a one-word frame.
    new_phase();
    x = $urandom_range(0, 3);
    add_frame(3068, 1536, x); push_desc(3068, 1536, x);
    add_frame(1530, 2, 0);    push_desc(1530, 2, 0);
    x = $urandom_range(0, 3);
    add_frame(4600, 3072, x); push_desc(4600, 3072, x);
    add_frame(777, 777, 1);   push_desc(777, 777, 1);
    wait_frames("t2", 4, 1000, 1'b1);
    compare_phase("t2");

    // Random frames with random backpressure.
    new_phase();
    for (int i = 0; i < 6; i++) begin
      rand_desc(12, s, e, x);
      add_frame(s, e, x);
      push_desc(s, e, x);
    end
    wait_frames("t3", 6, 2000, 1'b1);
    compare_phase("t3");

    // Long stall mid-frame while the descriptor queue is overfilled.
    new_phase();
    add_frame(100, 160, 3);
    push_desc(100, 160, 3);
    c = 0;
    while ((got_q.size() - gb < 3) && (c < 100)) begin
      @(negedge i_clk);
      c++;
    end
    i_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge i_clk);
      rand_desc(6, s, e, x);
      i_desc    = {2'(x), AW'(e), AW'(s)};
      i_desc_we = 1'b1;
      if (i < 8) add_frame(s, e, x);
    end
    @(negedge i_clk);
    i_desc_we = 1'b0;
    chk("qfull_err_pulse", o_err, 1);
    chk("qfull_cnt", o_desc_cnt, 8);
    chk("qfull_full", o_desc_full, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      chk("stall_valid", o_valid, 1);
      if (got_q.size() - gb < exp_q.size())
        chk("stall_data", o_data, exp_q[got_q.size() - gb].d);
      chk("stall_outstanding_ok", 64'((rd_q.size() - rb) - (got_q.size() - gb) <= 4), 1);
    end
    chk("stall_no_accept", 64'(got_q.size() - gb), 3);
    wait_frames("t4", 9, 3000, 1'b1);
    compare_phase("t4");
    chk("t4_err_count", 64'(err_cnt - eb), 1);

    // Bad descriptors are dropped without reads; the next good one is served.
    new_phase();
    push_desc(1500, 1600, 0);
    repeat (10) @(negedge i_clk);
    chk("bad_cross_err", 64'(err_cnt - eb), 1);
    chk("bad_cross_noread", 64'(rd_q.size() - rb), 0);
    push_desc(5000, 5001, 0);
    repeat (10) @(negedge i_clk);
    chk("bad_range_err", 64'(err_cnt - eb), 2);
    chk("bad_range_noread", 64'(rd_q.size() - rb), 0);
    chk("bad_queue_empty", o_desc_cnt, 0);
    add_frame(200, 203, 1);
    push_desc(200, 203, 1);
    wait_frames("t5", 1, 200, 1'b0);
    compare_phase("t5");

    // Reset in the middle of a frame.
    push_desc(300, 400, 0);
    push_desc(40, 45, 1);
    repeat (12) @(negedge i_clk);
    chk("pre_reset_reading", o_en_read, 1);
    i_reset = 1'b1;
    @(negedge i_clk);
    chk_all_zero("midreset");
    i_reset = 1'b0;
    vb = got_q.size();
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      chk("post_reset_valid", o_valid, 0);
    end
    chk("post_reset_no_words", 64'(got_q.size() - vb), 0);
    new_phase();
    add_frame(20, 25, 2);
    push_desc(20, 25, 2);
    wait_frames("t6", 1, 200, 1'b1);
    compare_phase("t6");

    chk("max_outstanding_ok", 64'(max_outst <= 4), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
